// File: rtl/jbi_pktout_seq.sv
// Outbound JBus packet sequencer: steps one granted request through its bus
// cycles, pops the source queue on the last beat and inserts an idle gap.
module jbi_pktout_seq #(
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_vld,
  input  logic [2:0] req_queue,
  input  logic       req_wr,
  input  logic       req_nack,
  output logic       req_ack,
  output logic [2:0] sel_queue,
  output logic [3:0] sel_j_adbus,
  output logic [3:0] sct_rdq_pop,
  output logic       pio_rqq_pop,
  output logic       pio_ackq_pop,
  output logic       dbgq_pop,
  output logic       pkt_busy,
  output logic       illegal_req
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int         GAP_M1   = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam logic [1:0] GAP_LOAD = 2'(GAP_M1);

  // Index of the final beat for a given request type.
  function automatic logic [1:0] last_beat(input logic [2:0] q, input logic wr);
    case (q)
      3'd4:       last_beat = wr ? 2'd1 : 2'd0;
      3'd5, 3'd7: last_beat = 2'd0;
      3'd6:       last_beat = 2'd1;
      default:    last_beat = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] beat_code(input logic [2:0] q, input logic nack,
                                           input logic [1:0] beat);
    case (q)
      3'd4:    beat_code = 4'd5 + {2'b00, beat};
      3'd5:    beat_code = nack ? 4'd8 : 4'd7;
      3'd6:    beat_code = 4'd9 + {2'b00, beat};
      3'd7:    beat_code = 4'd0;
      default: beat_code = 4'd1 + {2'b00, beat};
    endcase
  endfunction

  logic [1:0] state_reg, state_next;
  logic [1:0] beat_reg, beat_next;
  logic [1:0] gap_reg, gap_next;
  logic [2:0] q_reg, q_next;
  logic       wr_reg, wr_next;
  logic       nack_reg, nack_next;
  logic [2:0] sel_q_reg, sel_q_next;
  logic [3:0] sel_j_reg, sel_j_next;
  logic       pop_reg, pop_next;
  logic       last_cur;
  logic       accept;

  assign last_cur = (beat_reg == last_beat(q_reg, wr_reg));

  // With no gap, the last beat cycle can already accept the following packet.
  assign accept = req_vld && !rst &&
                  ((state_reg == ST_IDLE) ||
                   ((IDLE_GAP == 0) && (state_reg == ST_PKT) && last_cur));

  assign req_ack     = accept;
  assign illegal_req = accept && (req_queue == 3'd7);
  assign pkt_busy    = (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    gap_next   = gap_reg;
    q_next     = q_reg;
    wr_next    = wr_reg;
    nack_next  = nack_reg;
    sel_q_next = 3'd0;
    sel_j_next = 4'd0;
    pop_next   = 1'b0;

    case (state_reg)
      ST_PKT: begin
        if (!last_cur) begin
          beat_next  = beat_reg + 2'd1;
          sel_q_next = q_reg;
          sel_j_next = beat_code(q_reg, nack_reg, beat_reg + 2'd1);
          pop_next   = ((beat_reg + 2'd1) == last_beat(q_reg, wr_reg));
        end else if (IDLE_GAP > 0) begin
          state_next = ST_GAP;
          gap_next   = GAP_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_reg == 2'd0) state_next = ST_IDLE;
        else gap_next = gap_reg - 2'd1;
      end
      default: ;
    endcase

    if (accept) begin
      q_next    = req_queue;
      wr_next   = req_wr;
      nack_next = req_nack;
      beat_next = 2'd0;
      // Queue 7 is swallowed: acknowledged but never put on the bus.
      if (req_queue != 3'd7) begin
        state_next = ST_PKT;
        sel_q_next = req_queue;
        sel_j_next = beat_code(req_queue, req_nack, 2'd0);
        pop_next   = (last_beat(req_queue, req_wr) == 2'd0);
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      beat_reg  <= 2'd0;
      gap_reg   <= 2'd0;
      q_reg     <= 3'd0;
      wr_reg    <= 1'b0;
      nack_reg  <= 1'b0;
      sel_q_reg <= 3'd0;
      sel_j_reg <= 4'd0;
      pop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      gap_reg   <= gap_next;
      q_reg     <= q_next;
      wr_reg    <= wr_next;
      nack_reg  <= nack_next;
      sel_q_reg <= sel_q_next;
      sel_j_reg <= sel_j_next;
      pop_reg   <= pop_next;
    end
  end

  assign sel_queue   = sel_q_reg;
  assign sel_j_adbus = sel_j_reg;

  // sel_queue is only nonzero during a packet, so it doubles as the pop target.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sct_pop
      assign sct_rdq_pop[gi] = pop_reg && (sel_q_reg == 3'(gi));
    end
  endgenerate

  assign pio_rqq_pop  = pop_reg && (sel_q_reg == 3'd4);
  assign pio_ackq_pop = pop_reg && (sel_q_reg == 3'd5);
  assign dbgq_pop     = pop_reg && (sel_q_reg == 3'd6);

endmodule
